xsm_trigger_mc: RTL

- Multi-channel trigger engine for the XSM sensor path; successor to the single-channel level/edge trigger.
- Per-channel hysteresis comparators with debounce qualify rising/falling/level events.
- An arm/holdoff/single-shot controller emits one trigger pulse, tagged with source channel, direction and a free-running timestamp.
- Sits between the sample front-end and the capture/interrupt logic.

---
 rtl/xsm_trigger_mc.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/xsm_trigger_mc.sv
// xsm_trigger_mc: multi-channel hysteresis/debounce trigger engine.
// Arm/holdoff/single-shot control, tagged with channel, direction, timestamp.
module xsm_trigger_mc #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int TS_WIDTH   = 32,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] sample_data,
    input  logic [DATA_WIDTH-1:0]        thr_high,
    input  logic [DATA_WIDTH-1:0]        thr_low,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [1:0]                   mode,
    input  logic [CNT_WIDTH-1:0]         debounce_cnt,
    input  logic [CNT_WIDTH-1:0]         holdoff_cnt,
    input  logic                         single_shot,
    input  logic                         arm,
    input  logic                         clear,
    output logic                         trig_pulse,
    output logic [CH_W-1:0]              trig_ch,
    output logic                         trig_dir,
    output logic [TS_WIDTH-1:0]          trig_ts,
    output logic                         armed,
    output logic                         holdoff_busy,
    output logic [CNT_WIDTH-1:0]         missed_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLDOFF
    } state_t;

    state_t               state;
    logic [TS_WIDTH-1:0]  ts;
    logic [CNT_WIDTH-1:0] hcnt;
    logic [CNT_WIDTH-1:0] dcnt [NUM_CH];
    logic [NUM_CH-1:0]    zone;
    logic [NUM_CH-1:0]    zone_nx;
    logic [NUM_CH-1:0]    raw_hi;
    logic [NUM_CH-1:0]    raw_lo;
    logic [NUM_CH-1:0]    opp;
    logic [NUM_CH-1:0]    flip;
    logic [NUM_CH-1:0]    rise;
    logic [NUM_CH-1:0]    fall;
    logic [NUM_CH-1:0]    ev;
    logic [NUM_CH-1:0]    ev_dir;
    logic                 any_ev;
    logic [CH_W-1:0]      win_ch;
    logic                 win_dir;

    assign rise   = flip & ~zone;
    assign fall   = flip & zone;
    assign any_ev = |ev;

    assign armed        = (state == ARMED);
    assign holdoff_busy = (state == HOLDOFF);

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + TS_WIDTH'(1);
    end

    // Raw region per channel; HIGH wins when thresholds overlap.
    always_comb begin
        raw_hi = '0;
        raw_lo = '0;
        opp    = '0;
        flip   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw_hi[i] = sample_data[i*DATA_WIDTH +: DATA_WIDTH] >= thr_high;
            raw_lo[i] = !raw_hi[i] &&
                        (sample_data[i*DATA_WIDTH +: DATA_WIDTH] <= thr_low);
            opp[i]    = zone[i] ? raw_lo[i] : raw_hi[i];
            flip[i]   = sample_valid && opp[i] && (dcnt[i] == debounce_cnt);
        end
        zone_nx = zone ^ flip;
    end

    // Mode filter and channel enable on the committed events.
    always_comb begin
        ev     = '0;
        ev_dir = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            unique case (mode)
                2'b00: begin
                    ev[i]     = sample_valid && zone_nx[i];
                    ev_dir[i] = 1'b1;
                end
                2'b01: begin
                    ev[i]     = rise[i];
                    ev_dir[i] = 1'b1;
                end
                2'b10: begin
                    ev[i]     = fall[i];
                    ev_dir[i] = 1'b0;
                end
                default: begin
                    ev[i]     = rise[i] | fall[i];
                    ev_dir[i] = rise[i];
                end
            endcase
            ev[i] = ev[i] & ch_enable[i];
        end
    end

    // Lowest-index channel with an event wins.
    always_comb begin
        win_ch  = '0;
        win_dir = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ev[i]) begin
                win_ch  = CH_W'(i);
                win_dir = ev_dir[i];
            end
        end
    end

    // Zone and debounce tracking; runs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zone <= '0;
            for (int i = 0; i < NUM_CH; i++) dcnt[i] <= '0;
        end else if (sample_valid) begin
            zone <= zone_nx;
            for (int i = 0; i < NUM_CH; i++) begin
                if (opp[i] && !flip[i]) dcnt[i] <= dcnt[i] + CNT_WIDTH'(1);
                else                    dcnt[i] <= '0;
            end
        end
    end

    // Arm/holdoff/single-shot controller with registered trigger tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hcnt       <= '0;
            trig_pulse <= 1'b0;
            trig_ch    <= '0;
            trig_dir   <= 1'b0;
            trig_ts    <= '0;
            missed_cnt <= '0;
        end else begin
            trig_pulse <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                missed_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (arm) state <= ARMED;
                    end
                    ARMED: begin
                        if (any_ev) begin
                            trig_pulse <= 1'b1;
                            trig_ch    <= win_ch;
                            trig_dir   <= win_dir;
                            trig_ts    <= ts;
                            if (single_shot) begin
                                state <= IDLE;
                            end else if (holdoff_cnt != '0) begin
                                state <= HOLDOFF;
                                hcnt  <= holdoff_cnt - CNT_WIDTH'(1);
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (any_ev && (missed_cnt != '1))
                            missed_cnt <= missed_cnt + CNT_WIDTH'(1);
                        if (hcnt == '0) state <= ARMED;
                        else            hcnt  <= hcnt - CNT_WIDTH'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
